// File: rtl/reset_release_sequencer.sv
// Staged reset release: after rst (or a software request) every stage is held in reset,
// then the stages are released one at a time, bit 0 first, with a fixed gap between them.
module reset_release_sequencer #(
   parameter int unsigned NUM_STAGES  = 4,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 8,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  soft_req,
   output logic                  soft_ack,
   output logic [NUM_STAGES-1:0] stage_rstn,
   output logic                  all_ready,
   output logic                  busy
);

   localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [1:0] {HOLD, GAP, RUN} state_t;

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n;
   logic [IDX_W-1:0]        idx, idx_n;
   logic [NUM_STAGES-1:0]   stage_n;
   logic                    ready_n, busy_n, ack_n;

   // State and output registers; rst overrides everything, including a soft request
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HOLD;
         cnt        <= '0;
         idx        <= '0;
         stage_rstn <= '0;
         all_ready  <= 1'b0;
         busy       <= 1'b1;
         soft_ack   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         stage_rstn <= stage_n;
         all_ready  <= ready_n;
         busy       <= busy_n;
         soft_ack   <= ack_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      stage_n = stage_rstn;
      ready_n = all_ready;
      busy_n  = busy;
      ack_n   = 1'b0;
      case (state)
         HOLD: begin
            if (cnt == HOLD_LAST) begin
               stage_n[0] = 1'b1;
               cnt_n      = '0;
               if (NUM_STAGES == 1) begin
                  state_n = RUN;
                  ready_n = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  idx_n   = IDX_W'(1);
                  state_n = GAP;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               stage_n = stage_rstn | (NUM_STAGES'(1) << idx);
               cnt_n   = '0;
               if (idx == LAST_IDX) begin
                  state_n = RUN;
                  ready_n = 1'b1;
                  busy_n  = 1'b0;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (soft_req) begin
               state_n = HOLD;
               cnt_n   = '0;
               idx_n   = '0;
               stage_n = '0;
               ready_n = 1'b0;
               busy_n  = 1'b1;
               ack_n   = 1'b1;
            end
         end
         default: begin
            state_n = HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            stage_n = '0;
            ready_n = 1'b0;
            busy_n  = 1'b1;
         end
      endcase
   end

   // Delay values must fit the counter so that the terminal compare is reachable
   always_ff @(posedge clk) begin
      assert (NUM_STAGES >= 1) else $error("NUM_STAGES must be at least 1");
      assert (HOLD_CYCLES >= 1 && HOLD_CYCLES <= (1 << CNT_W))
         else $error("HOLD_CYCLES out of range for CNT_W");
      assert (GAP_CYCLES >= 1 && GAP_CYCLES <= (1 << CNT_W))
         else $error("GAP_CYCLES out of range for CNT_W");
   end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer: default 4-stage instance plus a
// single-stage, HOLD_CYCLES=1 instance, checked against hand-computed release edges.
module tb_reset_release_sequencer;

   logic       clk = 1'b0;
   logic       rst, soft_req, soft_ack;
   logic [3:0] stage_rstn;
   logic       all_ready, busy;

   logic       rst1, soft_req1, soft_ack1;
   logic [0:0] stage_rstn1;
   logic       all_ready1, busy1;

   int n_vec = 0;
   int n_err = 0;

   // Release edges (offset from E0) of stages 0..3 for HOLD=16, GAP=8
   int rel[4] = '{15, 23, 31, 39};

   always #5 clk = ~clk;

   reset_release_sequencer dut (
      .clk(clk), .rst(rst), .soft_req(soft_req), .soft_ack(soft_ack),
      .stage_rstn(stage_rstn), .all_ready(all_ready), .busy(busy)
   );

   reset_release_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1), .soft_req(soft_req1), .soft_ack(soft_ack1),
      .stage_rstn(stage_rstn1), .all_ready(all_ready1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle; inputs driven after this are seen at the next edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observe edges E0..E0+last_k; the first step lands on E0
   task automatic timeline(input string tag, input int last_k);
      logic [3:0] exp_stage;
      for (int k = 0; k <= last_k; k++) begin
         step();
         exp_stage = '0;
         for (int i = 0; i < 4; i++)
            if (k >= rel[i]) exp_stage[i] = 1'b1;
         chk($sformatf("%s stage k=%0d", tag, k), 32'(stage_rstn), 32'(exp_stage));
         chk($sformatf("%s ready k=%0d", tag, k), 32'(all_ready), 32'(k >= 39));
         chk($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(k < 39));
         chk($sformatf("%s ack k=%0d", tag, k), 32'(soft_ack), 32'd0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " stage"}, 32'(stage_rstn), 32'd0);
      chk({tag, " ready"}, 32'(all_ready), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " ack"}, 32'(soft_ack), 32'd0);
   endtask

   initial begin
      rst = 1'b1; soft_req = 1'b0;
      rst1 = 1'b1; soft_req1 = 1'b0;

      // 1: defaults after a 5-cycle reset
      for (int i = 0; i < 5; i++) step();
      chk_reset_vals("t1 reset");
      rst = 1'b0;
      timeline("t1", 41);

      // 2: reset re-asserted while stage_rstn=0011
      rst = 1'b1; step(); rst = 1'b0;
      timeline("t2a", 27);
      chk("t2 pre-abort stage", 32'(stage_rstn), 32'h3);
      rst = 1'b1; step();
      chk_reset_vals("t2 abort");
      rst = 1'b0;
      timeline("t2b", 41);

      // 3: single-cycle soft request in RUN
      soft_req = 1'b1; step(); soft_req = 1'b0;
      chk("t3 ack", 32'(soft_ack), 32'd1);
      chk("t3 stage", 32'(stage_rstn), 32'd0);
      chk("t3 ready", 32'(all_ready), 32'd0);
      chk("t3 busy", 32'(busy), 32'd1);
      timeline("t3", 41);

      // 4: soft request held through HOLD/GAP is ignored, then fires on first RUN edge
      rst = 1'b1; step(); rst = 1'b0;
      soft_req = 1'b1;
      timeline("t4a", 39);
      step();
      chk("t4 ack", 32'(soft_ack), 32'd1);
      chk("t4 stage", 32'(stage_rstn), 32'd0);
      chk("t4 busy", 32'(busy), 32'd1);
      soft_req = 1'b0;
      timeline("t4b", 41);

      // 5: rst and soft_req together in RUN
      rst = 1'b1; soft_req = 1'b1; step();
      chk_reset_vals("t5");
      rst = 1'b0; soft_req = 1'b0;
      step();
      chk("t5 post ack", 32'(soft_ack), 32'd0);

      // 6: one stage, HOLD_CYCLES=1
      chk("t6 rst stage", 32'(stage_rstn1), 32'd0);
      chk("t6 rst busy", 32'(busy1), 32'd1);
      rst1 = 1'b0; step();
      chk("t6 E0 stage", 32'(stage_rstn1), 32'd1);
      chk("t6 E0 ready", 32'(all_ready1), 32'd1);
      chk("t6 E0 busy", 32'(busy1), 32'd0);
      soft_req1 = 1'b1; step(); soft_req1 = 1'b0;
      chk("t6 soft ack", 32'(soft_ack1), 32'd1);
      chk("t6 soft stage", 32'(stage_rstn1), 32'd0);
      step();
      chk("t6 rerun stage", 32'(stage_rstn1), 32'd1);
      chk("t6 rerun ready", 32'(all_ready1), 32'd1);
      chk("t6 rerun ack", 32'(soft_ack1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
